// File: rtl/vid_fill_arb.sv
// Linear fill engine plus write-port arbiter in front of the video memory write port.
// CPU writes always win; the engine stalls on contention and never drops or repeats a word.
module vid_fill_arb #(
    parameter int unsigned MEM_WORDS = 24576,
    parameter int unsigned AW        = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          reg_stb,
    input  logic          reg_we,
    input  logic [1:0]    reg_addr,
    input  logic [31:0]   reg_din,
    output logic [31:0]   reg_dout,
    input  logic          cpu_stb,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_data,
    output logic          mem_stb,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_data,
    output logic          irq
);

    localparam logic [AW-1:0] LastAddr = AW'(MEM_WORDS - 1);
    localparam logic [AW-1:0] MaxCount = AW'(MEM_WORDS);

    typedef enum logic {StIdle, StRun} state_e;

    state_e        state_q;
    logic [AW-1:0] start_q;
    logic [AW-1:0] count_q;
    logic [AW-1:0] cur_q;
    logic [AW-1:0] rem_q;
    logic [31:0]   pattern_q;
    logic          ie_q, done_q, aborted_q;
    logic          ie_d, done_d, aborted_d;

    logic          busy;
    logic          reg_wr;
    logic          reg_rd;
    logic          ctrl_wr;
    logic          go;
    logic          abort;
    logic          grant;
    logic          last;
    logic [31:0]   rd_data;

    assign busy    = (state_q == StRun);
    assign reg_wr  = reg_stb & reg_we;
    assign reg_rd  = reg_stb & ~reg_we;
    assign ctrl_wr = reg_wr & (reg_addr == 2'd3);
    // Abort wins over a simultaneous go.
    assign go      = ctrl_wr & reg_din[0] & ~reg_din[1];
    assign abort   = ctrl_wr & reg_din[1];
    assign grant   = busy & ~cpu_stb & ~abort;
    assign last    = grant & (rem_q == AW'(1));

    always_comb begin
        rd_data = '0;
        case (reg_addr)
            2'd0:    rd_data = {{(32-AW){1'b0}}, start_q};
            2'd1:    rd_data = {{(32-AW){1'b0}}, count_q};
            2'd2:    rd_data = pattern_q;
            default: rd_data = {28'b0, aborted_q, ie_q, done_q, busy};
        endcase
    end

    // Read-clear is applied first so a completion on the same edge still sets done.
    always_comb begin
        ie_d      = ie_q;
        done_d    = done_q;
        aborted_d = aborted_q;
        if (reg_rd && reg_addr == 2'd3) begin
            done_d    = 1'b0;
            aborted_d = 1'b0;
        end
        if (ctrl_wr) begin
            ie_d = reg_din[2];
        end
        if (busy) begin
            if (abort) begin
                done_d    = 1'b0;
                aborted_d = 1'b1;
            end else if (last) begin
                done_d = 1'b1;
            end
        end else if (go) begin
            done_d    = (count_q == '0);
            aborted_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            start_q   <= '0;
            count_q   <= '0;
            cur_q     <= '0;
            rem_q     <= '0;
            pattern_q <= '0;
            ie_q      <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            reg_dout  <= '0;
            mem_stb   <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
            irq       <= 1'b0;
        end else begin
            ie_q      <= ie_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            irq       <= done_d & ie_d;

            if (reg_rd) begin
                reg_dout <= rd_data;
            end

            if (reg_wr && !busy) begin
                case (reg_addr)
                    2'd0: start_q <= reg_din[AW-1:0];
                    2'd1: count_q <= (reg_din > 32'(MEM_WORDS)) ? MaxCount : reg_din[AW-1:0];
                    2'd2: pattern_q <= reg_din;
                    default: ;
                endcase
            end

            case (state_q)
                StIdle: begin
                    if (go && count_q != '0) begin
                        state_q <= StRun;
                        cur_q   <= start_q;
                        rem_q   <= count_q;
                    end
                end
                StRun: begin
                    if (abort) begin
                        state_q <= StIdle;
                    end else if (grant) begin
                        cur_q <= (cur_q == LastAddr) ? '0 : cur_q + 1'b1;
                        rem_q <= rem_q - 1'b1;
                        if (last) begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Address and data hold their last value when the port is idle.
            if (cpu_stb) begin
                mem_stb  <= 1'b1;
                mem_addr <= cpu_addr;
                mem_data <= cpu_data;
            end else if (grant) begin
                mem_stb  <= 1'b1;
                mem_addr <= cur_q;
                mem_data <= pattern_q;
            end else begin
                mem_stb <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vid_fill_arb.sv
// Bench for vid_fill_arb: directed scenarios plus random traffic against a queue-based model.
module tb_vid_fill_arb;
    localparam int MEM_WORDS = 24576;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_stb, reg_we;
    logic [1:0]  reg_addr;
    logic [31:0] reg_din, reg_dout;
    logic        cpu_stb;
    logic [14:0] cpu_addr;
    logic [31:0] cpu_data;
    logic        mem_stb;
    logic [14:0] mem_addr;
    logic [31:0] mem_data;
    logic        irq;

    always #5 clk = ~clk;

    vid_fill_arb dut (
        .clk      (clk),
        .rst      (rst),
        .reg_stb  (reg_stb),
        .reg_we   (reg_we),
        .reg_addr (reg_addr),
        .reg_din  (reg_din),
        .reg_dout (reg_dout),
        .cpu_stb  (cpu_stb),
        .cpu_addr (cpu_addr),
        .cpu_data (cpu_data),
        .mem_stb  (mem_stb),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .irq      (irq)
    );

    int n_total = 0;
    int n_bad   = 0;
    int n_obs   = 0;

    // Model: a fill is just the queue of word addresses still to be written.
    int          m_start, m_count;
    logic [31:0] m_pat;
    bit          m_ie, m_done, m_abt;
    int          pend[$];
    bit          e_stb;
    int          e_addr;
    logic [31:0] e_data, e_dout;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_start = 0; m_count = 0; m_pat = '0;
        m_ie = 0; m_done = 0; m_abt = 0;
        pend.delete();
        e_stb = 0; e_addr = 0; e_data = '0; e_dout = '0;
    endtask

    task automatic model_edge();
        bit busy = (pend.size() != 0);
        bit rd   = reg_stb && !reg_we;
        bit wr   = reg_stb && reg_we;
        bit ctl  = wr && (reg_addr == 2'd3);
        bit go   = ctl && reg_din[0];
        bit ab   = ctl && reg_din[1];
        if (rst) begin
            model_reset();
            return;
        end
        if (rd) begin
            case (reg_addr)
                2'd0: e_dout = 32'(m_start);
                2'd1: e_dout = 32'(m_count);
                2'd2: e_dout = m_pat;
                default: begin
                    e_dout = {28'b0, m_abt, m_ie, m_done, busy};
                    m_done = 0;
                    m_abt  = 0;
                end
            endcase
        end
        e_stb = 0;
        if (cpu_stb) begin
            e_stb = 1; e_addr = int'(cpu_addr); e_data = cpu_data;
        end else if (busy && !ab) begin
            e_stb = 1; e_addr = pend.pop_front(); e_data = m_pat;
            if (pend.size() == 0) m_done = 1;
        end
        if (ctl) m_ie = reg_din[2];
        if (busy && ab) begin
            pend.delete();
            m_abt = 1; m_done = 0;
        end else if (!busy && go && !ab) begin
            m_abt  = 0;
            m_done = (m_count == 0);
            for (int i = 0; i < m_count; i++) pend.push_back((m_start + i) % MEM_WORDS);
        end
        if (wr && !busy) begin
            case (reg_addr)
                2'd0: m_start = int'(reg_din[14:0]);
                2'd1: m_count = (reg_din > 32'(MEM_WORDS)) ? MEM_WORDS : int'(reg_din[14:0]);
                2'd2: m_pat = reg_din;
                default: ;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("mem_stb", 32'(mem_stb), 32'(e_stb));
        check("mem_addr", 32'(mem_addr), 32'(e_addr));
        check("mem_data", mem_data, e_data);
        check("irq", 32'(irq), 32'(m_done & m_ie));
        check("reg_dout", reg_dout, e_dout);
        if (mem_stb) n_obs++;
        reg_stb = 0; reg_we = 0; rst = 0;
    endtask

    task automatic wreg(input logic [1:0] a, input logic [31:0] d);
        reg_stb = 1; reg_we = 1; reg_addr = a; reg_din = d;
        tick();
    endtask

    task automatic rreg(input logic [1:0] a);
        reg_stb = 1; reg_we = 0; reg_addr = a; reg_din = '0;
        tick();
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (pend.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        if (k == budget) check("wait_idle_timeout", 32'(k), 32'(0));
    endtask

    initial begin
        int k;
        rst = 1; reg_stb = 0; reg_we = 0; reg_addr = '0; reg_din = '0;
        cpu_stb = 0; cpu_addr = '0; cpu_data = '0;
        model_reset();
        rst = 1; tick();
        rst = 1; tick();
        check("rst_mem_stb", 32'(mem_stb), 32'd0);
        check("rst_dout", reg_dout, 32'd0);
        rreg(2'd3);
        check("rst_status", reg_dout, 32'd0);

        // Basic fill
        wreg(2'd0, 32'd0); wreg(2'd1, 32'd32); wreg(2'd2, 32'hFFFF_FFFF);
        n_obs = 0;
        wreg(2'd3, 32'h1);
        wait_idle(100);
        tick(); tick();
        check("basic_count", 32'(n_obs), 32'd32);
        rreg(2'd3);
        check("basic_status", reg_dout, 32'h2);

        // Contention: CPU holds the port for two cycles mid-run
        wreg(2'd0, 32'd100); wreg(2'd1, 32'd4);
        n_obs = 0;
        wreg(2'd3, 32'h1);
        tick();
        cpu_stb = 1; cpu_addr = 15'd5; cpu_data = 32'hA5A5_A5A5;
        tick(); tick();
        cpu_stb = 0;
        wait_idle(50);
        tick(); tick();
        check("contention_count", 32'(n_obs), 32'd6);

        // Wrap at the top of memory
        wreg(2'd0, 32'd24574); wreg(2'd1, 32'd4); wreg(2'd2, 32'h1234_5678);
        wreg(2'd3, 32'h1);
        wait_idle(50);
        rreg(2'd3);
        check("wrap_status", reg_dout, 32'h2);

        // Abort after 10 engine writes
        wreg(2'd1, 32'd1000);
        n_obs = 0;
        wreg(2'd3, 32'h1);
        k = 0;
        while (n_obs < 10 && k < 100) begin tick(); k++; end
        if (k == 100) check("abort_wait_timeout", 32'(k), 32'd0);
        wreg(2'd3, 32'h2);
        repeat (5) tick();
        check("abort_count_le11", 32'(n_obs <= 11), 32'd1);
        rreg(2'd3);
        check("abort_status", reg_dout, 32'h8);

        // Zero count: done, no writes
        wreg(2'd1, 32'd0);
        n_obs = 0;
        wreg(2'd3, 32'h1);
        repeat (3) tick();
        check("zero_count_writes", 32'(n_obs), 32'd0);
        rreg(2'd3);
        check("zero_status", reg_dout, 32'h2);

        // START write and second go ignored while busy
        wreg(2'd0, 32'd0); wreg(2'd1, 32'd20);
        wreg(2'd3, 32'h1);
        tick();
        wreg(2'd0, 32'd7);
        wreg(2'd3, 32'h1);
        wait_idle(100);
        rreg(2'd0);
        check("ignore_start", reg_dout, 32'd0);

        // COUNT clamps to MEM_WORDS
        wreg(2'd1, 32'd30000);
        rreg(2'd1);
        check("count_clamp", reg_dout, 32'd24576);

        // Interrupt and read-clear
        wreg(2'd3, 32'h4);
        wreg(2'd0, 32'd50); wreg(2'd1, 32'd2);
        wreg(2'd3, 32'h5);
        wait_idle(20);
        tick();
        check("irq_set", 32'(irq), 32'd1);
        rreg(2'd3);
        check("irq_status1", reg_dout, 32'h6);
        rreg(2'd3);
        check("irq_status2", reg_dout, 32'h4);
        check("irq_clear", 32'(irq), 32'd0);

        // Reset mid-fill
        wreg(2'd1, 32'd100);
        wreg(2'd3, 32'h5);
        repeat (5) tick();
        rst = 1; tick();
        check("midrst_stb", 32'(mem_stb), 32'd0);
        check("midrst_addr", 32'(mem_addr), 32'd0);
        check("midrst_data", mem_data, 32'd0);
        check("midrst_irq", 32'(irq), 32'd0);
        check("midrst_dout", reg_dout, 32'd0);
        tick();
        check("midrst_idle_stb", 32'(mem_stb), 32'd0);

        // Random traffic
        for (int it = 0; it < 30; it++) begin
            wreg(2'd0, 32'($urandom_range(0, MEM_WORDS - 1)));
            wreg(2'd1, 32'($urandom_range(0, 40)));
            wreg(2'd2, $urandom);
            wreg(2'd3, 32'(($urandom_range(0, 1) << 2) | 1));
            for (int c = 0; c < 50; c++) begin
                int r;
                logic [1:0] a;
                cpu_stb  = ($urandom_range(0, 3) == 0);
                cpu_addr = 15'($urandom);
                cpu_data = $urandom;
                r = $urandom_range(0, 9);
                a = 2'($urandom_range(0, 3));
                if (r == 0) begin
                    rreg(a);
                end else if (r == 1) begin
                    case (a)
                        2'd0: wreg(a, 32'($urandom_range(0, MEM_WORDS - 1)));
                        2'd1: wreg(a, 32'($urandom_range(0, 40)));
                        2'd2: wreg(a, $urandom);
                        default: wreg(a, 32'($urandom_range(0, 7)));
                    endcase
                end else begin
                    tick();
                end
            end
            cpu_stb = 0;
            wait_idle(200);
            rreg(2'd3);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
